// File: rtl/hazard_scoreboard_pkg.sv
// rtl/hazard_scoreboard_pkg.sv - shared encodings and scoreboard entry type
package hazard_scoreboard_pkg;

  localparam logic [1:0] WD_ALU = 2'd0;
  localparam logic [1:0] WD_RAM = 2'd1;
  localparam logic [1:0] WD_PC4 = 2'd2;
  localparam logic [1:0] WD_IMM = 2'd3;

  localparam int FWD_RF = 0;
  localparam int REG_W  = 5;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] wr;
    logic             is_load;
  } sb_entry_t;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// rtl/hazard_scoreboard_if.sv - ID-stage decode inputs and hazard outputs
interface hazard_scoreboard_if #(
  parameter int STAGES = 3,
  parameter int FW     = $clog2(STAGES + 1)
);
  logic              id_valid;
  logic [4:0]        id_rR1;
  logic              id_rR1_re;
  logic [4:0]        id_rR2;
  logic              id_rR2_re;
  logic [4:0]        id_wR;
  logic              id_rf_we;
  logic [1:0]        id_wd_sel;
  logic              flush;
  logic              hold;
  logic              stall;
  logic [FW-1:0]     fwd1_sel;
  logic [FW-1:0]     fwd2_sel;
  logic [STAGES-1:0] sb_valid;
  logic [31:0]       stall_cnt;

  modport master (
    output id_valid, id_rR1, id_rR1_re, id_rR2, id_rR2_re,
           id_wR, id_rf_we, id_wd_sel, flush, hold,
    input  stall, fwd1_sel, fwd2_sel, sb_valid, stall_cnt
  );

  modport slave (
    input  id_valid, id_rR1, id_rR1_re, id_rR2, id_rR2_re,
           id_wR, id_rf_we, id_wd_sel, flush, hold,
    output stall, fwd1_sel, fwd2_sel, sb_valid, stall_cnt
  );
endinterface

// File: rtl/hazard_scoreboard_sb_match.sv
// rtl/hazard_scoreboard_sb_match.sv - youngest-entry match of one source operand
module hazard_scoreboard_sb_match
  import hazard_scoreboard_pkg::*;
#(
  parameter int STAGES = 3,
  localparam int IW    = $clog2(STAGES)
) (
  input  sb_entry_t [STAGES-1:0] entries_i,
  input  logic [REG_W-1:0]       rr_i,
  input  logic                   re_i,
  output logic                   hit_o,
  output logic [IW-1:0]          idx_o,
  output logic                   is_load_o
);

  // Scan oldest to youngest so the lowest matching index is left standing.
  always_comb begin
    hit_o     = 1'b0;
    idx_o     = '0;
    is_load_o = 1'b0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      if (re_i && (rr_i != '0) && entries_i[k].valid && (entries_i[k].wr == rr_i)) begin
        hit_o     = 1'b1;
        idx_o     = IW'(k);
        is_load_o = entries_i[k].is_load;
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - LA32R ID-stage interlock, forwarding select and stall counter
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int  STAGES   = 3,
  parameter int  FWD_EN   = 1,
  parameter int  LOAD_LAT = 1,
  localparam int FW       = $clog2(STAGES + 1)
) (
  input logic               cpu_clk,
  input logic               cpu_rstn,
  hazard_scoreboard_if.slave hz
);

  localparam int            IW  = $clog2(STAGES);
  localparam logic          FWD = (FWD_EN != 0);
  localparam logic [IW-1:0] LL  = IW'(LOAD_LAT);

  sb_entry_t [STAGES-1:0] sb_q, sb_d;
  logic [31:0]            stall_cnt_q, stall_cnt_d;

  logic          hit1, hit2, ld1, ld2, rdy1, rdy2, stall_w;
  logic [IW-1:0] idx1, idx2;

  hazard_scoreboard_sb_match #(.STAGES(STAGES)) u_match1 (
    .entries_i (sb_q),
    .rr_i      (hz.id_rR1),
    .re_i      (hz.id_rR1_re),
    .hit_o     (hit1),
    .idx_o     (idx1),
    .is_load_o (ld1)
  );

  hazard_scoreboard_sb_match #(.STAGES(STAGES)) u_match2 (
    .entries_i (sb_q),
    .rr_i      (hz.id_rR2),
    .re_i      (hz.id_rR2_re),
    .hit_o     (hit2),
    .idx_o     (idx2),
    .is_load_o (ld2)
  );

  // Load data only exists from entry LOAD_LAT onward; without forwarding nothing is ready.
  assign rdy1 = !hit1 || (FWD && (!ld1 || (idx1 >= LL)));
  assign rdy2 = !hit2 || (FWD && (!ld2 || (idx2 >= LL)));

  assign stall_w     = hz.id_valid && !hz.flush && (!rdy1 || !rdy2);
  assign hz.stall    = stall_w;
  assign hz.fwd1_sel = (FWD && hit1 && rdy1) ? (FW'(idx1) + FW'(1)) : FW'(FWD_RF);
  assign hz.fwd2_sel = (FWD && hit2 && rdy2) ? (FW'(idx2) + FW'(1)) : FW'(FWD_RF);
  assign hz.stall_cnt = stall_cnt_q;

  always_comb begin
    hz.sb_valid = '0;
    for (int k = 0; k < STAGES; k++) begin
      hz.sb_valid[k] = sb_q[k].valid;
    end
  end

  always_comb begin
    sb_d        = sb_q;
    stall_cnt_d = stall_cnt_q;
    if (!hz.hold) begin
      for (int k = STAGES - 1; k >= 1; k--) begin
        sb_d[k] = sb_q[k-1];
      end
      sb_d[0] = '0;
      // Only real, surviving register writers (never r0) occupy a slot.
      if (hz.id_valid && !stall_w && !hz.flush && hz.id_rf_we && (hz.id_wR != '0)) begin
        sb_d[0].valid   = 1'b1;
        sb_d[0].wr      = hz.id_wR;
        sb_d[0].is_load = (hz.id_wd_sel == WD_RAM);
      end
      if (stall_w && (stall_cnt_q != '1)) begin
        stall_cnt_d = stall_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      sb_q        <= '0;
      stall_cnt_q <= '0;
    end else begin
      sb_q        <= sb_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - vector table, model-checked random run and interlock-only corners
module tb_hazard_scoreboard;
  import hazard_scoreboard_pkg::*;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  hazard_scoreboard_if #(.STAGES(3)) hz ();
  hazard_scoreboard_if #(.STAGES(3)) hz2 ();

  hazard_scoreboard #(.STAGES(3), .FWD_EN(1), .LOAD_LAT(1)) dut (
    .cpu_clk (clk), .cpu_rstn (rstn), .hz (hz.slave));
  hazard_scoreboard #(.STAGES(3), .FWD_EN(0), .LOAD_LAT(1)) dut2 (
    .cpu_clk (clk), .cpu_rstn (rstn), .hz (hz2.slave));

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic v; logic [4:0] r1; logic re1; logic [4:0] r2; logic re2;
    logic [4:0] wr; logic we; logic [1:0] wd; logic fl; logic ho;
    logic st; logic [1:0] f1; logic [1:0] f2; logic [2:0] sbv; logic [31:0] cnt;
  } tv_t;
  tv_t tv[$];

  typedef struct { bit v; bit [4:0] wr; bit ld; } ment_t;
  ment_t m_sb[$];
  logic [31:0] m_cnt;

  function automatic tv_t mk(logic v, logic [4:0] r1, logic re1, logic [4:0] r2, logic re2,
                             logic [4:0] wr, logic we, logic [1:0] wd, logic fl, logic ho,
                             logic st, logic [1:0] f1, logic [1:0] f2, logic [2:0] sbv,
                             logic [31:0] cnt);
    tv_t t;
    t.v = v; t.r1 = r1; t.re1 = re1; t.r2 = r2; t.re2 = re2; t.wr = wr; t.we = we;
    t.wd = wd; t.fl = fl; t.ho = ho; t.st = st; t.f1 = f1; t.f2 = f2; t.sbv = sbv; t.cnt = cnt;
    return t;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic m_reset();
    ment_t z;
    z.v = 0; z.wr = 0; z.ld = 0;
    m_sb.delete();
    repeat (3) m_sb.push_back(z);
    m_cnt = 0;
  endtask

  // A producer k slots ahead is forwardable unless it is a load still in slot 0.
  function automatic int m_sel(input logic [4:0] r, input logic re, output bit rdy);
    rdy = 1'b1;
    if (!re || r == 5'd0) return 0;
    for (int k = 0; k < 3; k++) begin
      if (m_sb[k].v && m_sb[k].wr == r) begin
        rdy = !m_sb[k].ld || (k >= 1);
        return rdy ? k + 1 : 0;
      end
    end
    return 0;
  endfunction

  function automatic bit m_stall();
    bit a, b;
    int s1, s2;
    s1 = m_sel(hz.id_rR1, hz.id_rR1_re, a);
    s2 = m_sel(hz.id_rR2, hz.id_rR2_re, b);
    return hz.id_valid && !hz.flush && !(a && b);
  endfunction

  task automatic m_clock(input bit st);
    ment_t e;
    if (!hz.hold) begin
      e.v  = hz.id_valid && !st && !hz.flush && hz.id_rf_we && (hz.id_wR != 5'd0);
      e.wr = hz.id_wR;
      e.ld = (hz.id_wd_sel == WD_RAM);
      m_sb.push_front(e);
      void'(m_sb.pop_back());
      if (st && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] r1, input logic re1, input logic [4:0] r2,
                       input logic re2, input logic [4:0] wr, input logic we, input logic [1:0] wd,
                       input logic fl, input logic ho);
    hz.id_valid = v; hz.id_rR1 = r1; hz.id_rR1_re = re1; hz.id_rR2 = r2; hz.id_rR2_re = re2;
    hz.id_wR = wr; hz.id_rf_we = we; hz.id_wd_sel = wd; hz.flush = fl; hz.hold = ho;
  endtask

  task automatic drive2(input logic v, input logic [4:0] r1, input logic re1,
                        input logic [4:0] wr, input logic we);
    hz2.id_valid = v; hz2.id_rR1 = r1; hz2.id_rR1_re = re1; hz2.id_rR2 = 5'd0; hz2.id_rR2_re = 1'b0;
    hz2.id_wR = wr; hz2.id_rf_we = we; hz2.id_wd_sel = WD_ALU; hz2.flush = 1'b0; hz2.hold = 1'b0;
  endtask

  task automatic model_step(input string tag);
    bit a, b, st;
    int s1, s2;
    logic [2:0] sbv;
    #1;
    s1 = m_sel(hz.id_rR1, hz.id_rR1_re, a);
    s2 = m_sel(hz.id_rR2, hz.id_rR2_re, b);
    st = hz.id_valid && !hz.flush && !(a && b);
    sbv = {m_sb[2].v, m_sb[1].v, m_sb[0].v};
    check({tag, " stall"}, 32'(hz.stall), 32'(st));
    check({tag, " fwd1"}, 32'(hz.fwd1_sel), 32'(s1));
    check({tag, " fwd2"}, 32'(hz.fwd2_sel), 32'(s2));
    check({tag, " sb_valid"}, 32'(hz.sb_valid), 32'(sbv));
    check({tag, " stall_cnt"}, hz.stall_cnt, m_cnt);
    @(posedge clk);
    m_clock(st);
    @(negedge clk);
  endtask

  initial begin
    tv.push_back(mk(1, 1,1, 2,1,  3,1,WD_ALU,0,0, 0,0,0,3'b000,0));
    tv.push_back(mk(1, 3,1, 4,1,  5,1,WD_ALU,0,0, 0,1,0,3'b001,0));
    tv.push_back(mk(1, 3,1, 5,1,  0,0,WD_ALU,0,0, 0,2,1,3'b011,0));
    tv.push_back(mk(1, 3,1, 0,0,  4,1,WD_RAM,0,0, 0,3,0,3'b110,0));
    tv.push_back(mk(1, 4,1, 1,1,  6,1,WD_ALU,0,0, 1,0,0,3'b101,0));
    tv.push_back(mk(1, 4,1, 1,1,  6,1,WD_ALU,0,0, 0,2,0,3'b010,1));
    tv.push_back(mk(1, 1,1, 0,0,  5,1,WD_ALU,0,0, 0,0,0,3'b101,1));
    tv.push_back(mk(1, 5,1, 0,0,  5,1,WD_ALU,0,0, 0,1,0,3'b011,1));
    tv.push_back(mk(1, 5,1, 5,1,  0,0,WD_ALU,0,0, 0,1,1,3'b111,1));
    tv.push_back(mk(1, 0,1, 5,0,  0,1,WD_ALU,0,0, 0,0,0,3'b110,1));
    tv.push_back(mk(1, 0,0, 0,0,  7,1,WD_RAM,0,0, 0,0,0,3'b100,1));
    tv.push_back(mk(1, 7,1, 0,0,  8,1,WD_ALU,1,0, 0,0,0,3'b001,1));
    tv.push_back(mk(1, 7,1, 0,0,  9,1,WD_RAM,0,0, 0,2,0,3'b010,1));
    repeat (4) tv.push_back(mk(1, 9,1, 0,0, 10,1,WD_ALU,0,1, 1,0,0,3'b101,1));
    tv.push_back(mk(1, 9,1, 0,0, 10,1,WD_ALU,0,0, 1,0,0,3'b101,1));
    tv.push_back(mk(1, 9,1, 0,0, 10,1,WD_ALU,0,0, 0,2,0,3'b010,2));
    tv.push_back(mk(0,10,1, 0,0,  0,0,WD_ALU,0,0, 0,1,0,3'b101,2));

    drive(0, 0,0, 0,0, 0,0, WD_ALU, 0,0);
    drive2(0, 0,0, 0,0);
    m_reset();
    @(negedge clk);
    #1;
    check("reset stall", 32'(hz.stall), 32'd0);
    check("reset fwd1", 32'(hz.fwd1_sel), 32'd0);
    check("reset fwd2", 32'(hz.fwd2_sel), 32'd0);
    check("reset sb_valid", 32'(hz.sb_valid), 32'd0);
    check("reset stall_cnt", hz.stall_cnt, 32'd0);
    @(negedge clk);
    rstn = 1'b1;

    foreach (tv[i]) begin
      bit st;
      drive(tv[i].v, tv[i].r1, tv[i].re1, tv[i].r2, tv[i].re2,
            tv[i].wr, tv[i].we, tv[i].wd, tv[i].fl, tv[i].ho);
      #1;
      check($sformatf("vec%0d stall", i), 32'(hz.stall), 32'(tv[i].st));
      check($sformatf("vec%0d fwd1", i), 32'(hz.fwd1_sel), 32'(tv[i].f1));
      check($sformatf("vec%0d fwd2", i), 32'(hz.fwd2_sel), 32'(tv[i].f2));
      check($sformatf("vec%0d sb_valid", i), 32'(hz.sb_valid), 32'(tv[i].sbv));
      check($sformatf("vec%0d stall_cnt", i), hz.stall_cnt, tv[i].cnt);
      st = m_stall();
      @(posedge clk);
      m_clock(st);
      @(negedge clk);
    end

    // Fill every slot (load youngest), then pull reset between edges.
    drive(1, 0,0, 0,0, 1,1, WD_ALU, 0,0); model_step("fill0");
    drive(1, 0,0, 0,0, 2,1, WD_ALU, 0,0); model_step("fill1");
    drive(1, 0,0, 0,0, 3,1, WD_RAM, 0,0); model_step("fill2");
    drive(1, 3,1, 2,1, 9,1, WD_ALU, 0,0);
    #1;
    check("prerst sb_valid", 32'(hz.sb_valid), 32'h7);
    check("prerst stall", 32'(hz.stall), 32'd1);
    check("prerst fwd2", 32'(hz.fwd2_sel), 32'd2);
    #1;
    rstn = 1'b0;
    #1;
    check("midrst sb_valid", 32'(hz.sb_valid), 32'd0);
    check("midrst stall", 32'(hz.stall), 32'd0);
    check("midrst fwd1", 32'(hz.fwd1_sel), 32'd0);
    check("midrst fwd2", 32'(hz.fwd2_sel), 32'd0);
    check("midrst stall_cnt", hz.stall_cnt, 32'd0);
    @(posedge clk);
    m_reset();
    @(negedge clk);
    rstn = 1'b1;

    for (int n = 0; n < 600; n++) begin
      logic [1:0] wd;
      wd = ($urandom_range(0, 2) == 0) ? WD_RAM : 2'($urandom_range(0, 3));
      drive(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 4)), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 4)),
            1'($urandom_range(0, 1)), wd, ($urandom_range(0, 9) == 0), ($urandom_range(0, 7) == 0));
      model_step($sformatf("rnd%0d", n));
    end
    drive(0, 0,0, 0,0, 0,0, WD_ALU, 0,0);

    // Interlock-only instance: a dependency waits until the producer leaves WB.
    drive2(1, 0,0, 3,1);
    #1;
    check("nofwd producer stall", 32'(hz2.stall), 32'd0);
    @(negedge clk);
    drive2(1, 3,1, 5,1);
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("nofwd dep%0d stall", c), 32'(hz2.stall), 32'd1);
      check($sformatf("nofwd dep%0d fwd1", c), 32'(hz2.fwd1_sel), 32'd0);
      @(negedge clk);
    end
    #1;
    check("nofwd release stall", 32'(hz2.stall), 32'd0);
    check("nofwd stall_cnt", hz2.stall_cnt, 32'd3);
    @(negedge clk);
    force dut2.stall_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut2.stall_cnt_q;
    drive2(1, 5,1, 0,0);
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("sat%0d stall", c), 32'(hz2.stall), 32'd1);
      check($sformatf("sat%0d cnt", c), hz2.stall_cnt, (c == 0) ? 32'hFFFF_FFFE : 32'hFFFF_FFFF);
      @(negedge clk);
    end
    #1;
    check("sat end stall", 32'(hz2.stall), 32'd0);
    check("sat end cnt", hz2.stall_cnt, 32'hFFFF_FFFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised hazard, interlock and forwarding unit for the LA32R pipeline.
- Sits beside the ID stage and consumes the decoder's rR1_re/rR2_re, rf_we and wd_sel outputs plus the register indices of the instruction in ID.
- Keeps a shift-register scoreboard of in-flight destination writes, one entry per stage after ID (EX, MEM, WB, ...).
- Produces the ID stall, per-operand forwarding selects, and a saturating stall performance counter.

Parameters:
STAGES, 3, in-flight stages after ID; entry 0 = EX, entry STAGES-1 = WB; legal 2..7
FWD_EN, 1, 1 = forwarding enabled; 0 = stall-only interlock
LOAD_LAT, 1, first entry index whose load (WD_RAM) data is forwardable; legal 1..STAGES-1
FW, $clog2(STAGES+1), width of the forwarding selects (derived; not overridden)

Ports:
cpu_clk  in  1  clock, rising edge
cpu_rstn  in  1  asynchronous active-low reset
id_valid  in  1  ID holds a real instruction
id_rR1  in  5  source register 1 index
id_rR1_re  in  1  ID instruction reads rR1
id_rR2  in  5  source register 2 index
id_rR2_re  in  1  ID instruction reads rR2
id_wR  in  5  destination register index
id_rf_we  in  1  ID instruction writes the register file
id_wd_sel  in  2  write-back source; WD_RAM marks a load
flush  in  1  branch redirect; kill the ID instruction
hold  in  1  global pipeline freeze (memory wait)
stall  out  1  hold IF/ID and inject a bubble into EX
fwd1_sel  out  FW  operand-1 source: 0 = RF, k+1 = scoreboard entry k
fwd2_sel  out  FW  operand-2 source, same encoding
sb_valid  out  STAGES  per-entry valid bits (debug)
stall_cnt  out  32  count of stalled cycles

Behaviour:
- Entry fields: valid, wR[4:0], is_load. An entry is valid only if the instruction had rf_we=1 and wR!=0.
- Reset (async, cpu_rstn=0):
  - All entries cleared and stall_cnt=0.
  - Consequently stall=0, fwd1_sel=0, fwd2_sel=0, sb_valid=0.
  - Reset asserted mid-operation discards all in-flight entries immediately.
- Match for operand n (combinational): rRn_re=1, rRn!=0, and entry k valid with wR==rRn. The youngest entry (lowest k) wins. No match gives sel=0.
- Readiness of the winning entry k:
  - FWD_EN=1: non-load is always ready; a load is ready iff k>=LOAD_LAT.
  - FWD_EN=0: never ready; any match stalls until the entry has shifted out.
- fwdn_sel = k+1 if the winner is ready, else 0. Forced to 0 when FWD_EN=0.
- stall = id_valid & !flush & (operand-1 not ready | operand-2 not ready). Purely combinational, zero latency.
- Update on rising edge:
  - hold=1: all state frozen, stall_cnt unchanged.
  - hold=0: entry k takes entry k-1 for k>=1. Entry 0 takes the ID instruction if id_valid & !stall & !flush, otherwise a bubble (valid=0).
  - The oldest entry drops out.
- flush has priority over stall: during flush, stall=0 and a bubble enters EX.
- stall_cnt increments when stall=1 & hold=0 and saturates at 32'hFFFF_FFFF with no wrap.
- id_wd_sel==WD_RAM with rf_we=1 sets is_load. Stores and other non-writers never occupy an entry.
- Same-cycle write and read of the same register is resolved by forwarding from the WB entry. Register-file write-through is not relied on.

Decomposition:
- Shared package/defines: the WD_* encodings (WD_RAM reused from the decoder defines), FWD_RF=0, and the scoreboard entry field widths.
- One sub-module, sb_match: given entries and {rR, re}, returns hit, index of the youngest match, and is_load. Instantiated twice, once per operand.

Test Plan:
- Reset mid-stream: fill all 3 entries, pulse cpu_rstn low mid-cycle -> sb_valid=3'b000 immediately; stall=0, sels=0, stall_cnt=0.
- ALU dependency: add.w r3,r1,r2 then add.w r5,r3,r4 -> next cycle fwd1_sel=1, stall=0; a cycle later it is 2; stall_cnt stays 0.
- Load-use: ld.w r4 then add.w r6,r4,r1 -> stall=1 for exactly 1 cycle; sb_valid shows a bubble in entry 0; then fwd1_sel=2; stall_cnt=1.
- Youngest wins plus r0 and re gating:
  - addi r5 in entry 1 and addi r5 in entry 0, consumer reads r5 on both ports -> fwd1_sel=fwd2_sel=1.
  - A reader of r0, or rR2_re=0 with a matching rR2 -> sel=0, no stall.
- Hold and flush: hold=1 for 4 cycles during a load-use stall -> entries frozen, stall_cnt unchanged. Flush asserted together with the hazard -> stall=0 and entry 0 bubble next edge.
- FWD_EN=0, STAGES=3: add.w r3 then a consumer of r3 -> stall=1 for 3 cycles, sels always 0, stall_cnt=3. Then force stall_cnt to 32'hFFFF_FFFE and stall 3 more cycles -> saturates at 32'hFFFF_FFFF.
